// File: rtl/bcd_input_conditioner.sv
// bcd_input_conditioner
//   Conditions the Start/Load/Sel push-buttons and the BCD switch bank
//   for the seconds timer.
//   Each button goes through a synchroniser, a debouncer and an edge
//   detector, and ends up as a one-cycle press pulse.
// Ports
//   Clock, Reset    : system clock, async active-high reset
//   Enable          : gates the press pulses and the select toggle
//   Btn_Start/Load/Sel : raw buttons, 1 = pressed
//   Switches[7:0]   : raw BCD switches, tens in [7:4], ones in [3:0]
//   Start_Pulse     : one-cycle pulse per accepted Start press
//   Load_Pulse      : one-cycle pulse per accepted Load press
//   Target_Value    : clamped BCD value captured on Load
//   Bcd_Error       : the last capture had a nibble > 9
//   Display_Sel     : 0 = ones, 1 = tens; toggles per Sel press

// Per-button lane: 2-flop sync -> debounce counter -> stable level -> rise.
// Ports: clk, rst, btn (raw), rise (stable 0->1, one cycle, from flops).
module bcd_btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic        stable_q, stable_d;
  logic        prev_q;

  always_comb begin
    cnt_d    = 16'd0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      // Accept only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        stable_d = sync2_q;
        cnt_d    = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= 16'd0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  assign rise = stable_q & ~prev_q;
endmodule

module bcd_input_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Btn_Start,
  input  logic       Btn_Load,
  input  logic       Btn_Sel,
  input  logic [7:0] Switches,
  output logic       Start_Pulse,
  output logic       Load_Pulse,
  output logic [7:0] Target_Value,
  output logic       Bcd_Error,
  output logic       Display_Sel
);
  localparam int NUM_BTN = 3;
  localparam int B_START = 0, B_LOAD = 1, B_SEL = 2;

  logic [NUM_BTN-1:0] btn_raw, btn_rise;
  assign btn_raw = {Btn_Sel, Btn_Load, Btn_Start};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    bcd_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (Clock),
      .rst  (Reset),
      .btn  (btn_raw[i]),
      .rise (btn_rise[i])
    );
  end

  logic [7:0] sw1_q, sw2_q;
  logic       start_pulse_q, start_pulse_d;
  logic       load_pulse_q, load_pulse_d;
  logic [7:0] target_q, target_d;
  logic       err_q, err_d;
  logic       sel_q, sel_d;
  logic       tens_bad, ones_bad;

  assign tens_bad = sw2_q[7:4] > 4'd9;
  assign ones_bad = sw2_q[3:0] > 4'd9;

  always_comb begin
    load_pulse_d  = btn_rise[B_LOAD] & Enable;
    // Load has priority when both presses land on the same cycle.
    start_pulse_d = btn_rise[B_START] & Enable & ~btn_rise[B_LOAD];
    sel_d         = sel_q ^ (btn_rise[B_SEL] & Enable);
    target_d      = target_q;
    err_d         = err_q;
    if (load_pulse_d) begin
      target_d = {tens_bad ? 4'd9 : sw2_q[7:4], ones_bad ? 4'd9 : sw2_q[3:0]};
      err_d    = tens_bad | ones_bad;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sw1_q         <= 8'h00;
      sw2_q         <= 8'h00;
      start_pulse_q <= 1'b0;
      load_pulse_q  <= 1'b0;
      target_q      <= 8'h00;
      err_q         <= 1'b0;
      sel_q         <= 1'b0;
    end else begin
      sw1_q         <= Switches;
      sw2_q         <= sw1_q;
      start_pulse_q <= start_pulse_d;
      load_pulse_q  <= load_pulse_d;
      target_q      <= target_d;
      err_q         <= err_d;
      sel_q         <= sel_d;
    end
  end

  assign Start_Pulse  = start_pulse_q;
  assign Load_Pulse   = load_pulse_q;
  assign Target_Value = target_q;
  assign Bcd_Error    = err_q;
  assign Display_Sel  = sel_q;
endmodule

// File: tb/tb_bcd_input_conditioner.sv
module tb_bcd_input_conditioner;
  logic       Clock = 1'b0;
  logic       Reset, Enable, Btn_Start, Btn_Load, Btn_Sel;
  logic [7:0] Switches;
  logic       Start_Pulse, Load_Pulse, Bcd_Error, Display_Sel;
  logic [7:0] Target_Value;

  int tests = 0, fails = 0;
  int start_cnt = 0, load_cnt = 0;
  int s0, l0;

  bcd_input_conditioner #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable),
    .Btn_Start(Btn_Start), .Btn_Load(Btn_Load), .Btn_Sel(Btn_Sel),
    .Switches(Switches), .Start_Pulse(Start_Pulse), .Load_Pulse(Load_Pulse),
    .Target_Value(Target_Value), .Bcd_Error(Bcd_Error), .Display_Sel(Display_Sel)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (Start_Pulse === 1'b1) start_cnt++;
    if (Load_Pulse === 1'b1) load_cnt++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b1; Btn_Start = 1'b0; Btn_Load = 1'b0;
    Btn_Sel = 1'b0; Switches = 8'h00;
    tick(2);
    chk("reset_outs", {Start_Pulse, Load_Pulse, Target_Value, Bcd_Error, Display_Sel}, 0);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_outs", {Start_Pulse, Load_Pulse, Target_Value, Bcd_Error, Display_Sel}, 0);
    end

    // Load 47: pulse after edge 7, one cycle wide, value valid with the pulse
    Switches = 8'h47;
    tick(4);
    l0 = load_cnt;
    Btn_Load = 1'b1;
    tick(6);
    chk("load47_pre", Load_Pulse, 0);
    tick(1);
    chk("load47_pulse", Load_Pulse, 1);
    chk("load47_val_with_pulse", Target_Value, 8'h47);
    tick(1);
    chk("load47_width", Load_Pulse, 0);
    tick(2);
    Btn_Load = 1'b0;
    tick(15);
    chk("load47_count", load_cnt - l0, 1);
    chk("load47_target", Target_Value, 8'h47);
    chk("load47_err", Bcd_Error, 0);

    // Start glitches of 1..3 cycles are rejected
    s0 = start_cnt;
    for (int g = 1; g <= 3; g++) begin
      Btn_Start = 1'b1;
      tick(g);
      Btn_Start = 1'b0;
      tick(10);
    end
    chk("start_glitch", start_cnt - s0, 0);
    Btn_Start = 1'b1;
    tick(12);
    Btn_Start = 1'b0;
    tick(12);
    chk("start_held", start_cnt - s0, 1);

    // Clamp: A3 -> 93 with error
    Switches = 8'hA3;
    tick(4);
    Btn_Load = 1'b1; tick(10); Btn_Load = 1'b0; tick(10);
    chk("clampA3_target", Target_Value, 8'h93);
    chk("clampA3_err", Bcd_Error, 1);
    Switches = 8'h12;
    tick(4);
    Btn_Load = 1'b1; tick(10); Btn_Load = 1'b0; tick(10);
    chk("load12_target", Target_Value, 8'h12);
    chk("load12_err", Bcd_Error, 0);

    // Simultaneous Start+Load: Load wins
    s0 = start_cnt; l0 = load_cnt;
    Btn_Start = 1'b1; Btn_Load = 1'b1;
    tick(10);
    Btn_Start = 1'b0; Btn_Load = 1'b0;
    tick(10);
    chk("simul_load", load_cnt - l0, 1);
    chk("simul_start", start_cnt - s0, 0);

    // Three Sel presses toggle 1,0,1
    for (int k = 0; k < 3; k++) begin
      Btn_Sel = 1'b1; tick(8); Btn_Sel = 1'b0; tick(8);
      chk("sel_toggle", Display_Sel, (k % 2 == 0) ? 1 : 0);
    end

    // Disabled press must not fire after Enable rises; Sel holds too
    s0 = start_cnt;
    Enable = 1'b0;
    Btn_Start = 1'b1; Btn_Sel = 1'b1;
    tick(10);
    Enable = 1'b1;
    tick(5);
    Btn_Start = 1'b0; Btn_Sel = 1'b0;
    tick(10);
    chk("disabled_start", start_cnt - s0, 0);
    chk("disabled_sel_hold", Display_Sel, 1);

    // Reset mid-debounce of Load, held through release
    Btn_Load = 1'b1;
    tick(3);
    Reset = 1'b1;
    tick(2);
    chk("rst_mid_target", Target_Value, 8'h00);
    chk("rst_mid_sel", Display_Sel, 0);
    Reset = 1'b0;
    tick(6);
    chk("rst_reaccept_pre", Load_Pulse, 0);
    chk("rst_reaccept_target_pre", Target_Value, 8'h00);
    tick(1);
    chk("rst_reaccept_pulse", Load_Pulse, 1);
    chk("rst_reaccept_target", Target_Value, 8'h12);
    tick(1);
    chk("rst_reaccept_width", Load_Pulse, 0);
    Btn_Load = 1'b0;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_input_conditioner.md
# bcd_input_conditioner

Front-end stage feeding the seconds timer: conditions the raw Start, Load and digit-select push-buttons and the 8-bit BCD switch bank. Each button is synchronised, debounced and converted to a single-cycle press pulse. Load presses capture a validated two-digit BCD target value. The digit-select press toggles a display-select level used by the 7-segment mux.

## Interface
- DEBOUNCE_CYCLES, default 16'd50_000: consecutive stable cycles required before a button level is accepted; legal range 2..65535.
- Clock  in  1  system clock; the only clock in the block.
- Reset  in  1  asynchronous, active-high; clears all state.
- Enable  in  1  design enable; when low, all press pulses and the select toggle are suppressed.
- Btn_Start  in  1  raw asynchronous Start button, 1 = pressed.
- Btn_Load  in  1  raw asynchronous Load button, 1 = pressed.
- Btn_Sel  in  1  raw asynchronous digit-select button, 1 = pressed.
- Switches  in  8  raw BCD switches: [7:4] tens, [3:0] ones; quasi-static.
- Start_Pulse  out  1  one-cycle pulse per accepted Start press.
- Load_Pulse  out  1  one-cycle pulse per accepted Load press.
- Target_Value  out  8  validated BCD target, registered.
- Bcd_Error  out  1  high if the last captured Switches value held a nibble > 9.
- Display_Sel  out  1  toggles per accepted Sel press: 0 = ones, 1 = tens.

## Operation
- Per button: 2-flop synchroniser → debounce counter (16-bit) → stable level register → rising-edge detector.
- Debounce: the counter clears whenever the synchronised level equals the stable level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the stable level takes the synchronised level and the counter clears.
- A disagreement shorter than DEBOUNCE_CYCLES cycles never changes the stable level (glitch rejection).
- Pulse is generated on the stable 0→1 transition only. Release (1→0) is debounced identically but produces no pulse. A held button gives exactly one pulse.
- Enable low:
  - Pulses are forced 0 and Display_Sel holds.
  - Debouncers keep running, so a press accepted while disabled does not fire later when Enable rises.
- Load capture, on the cycle Load_Pulse is high:
  - Each Switches nibble is registered into Target_Value.
  - Any nibble > 9 is clamped to 4'd9.
  - Bcd_Error is set to 1 if any nibble was clamped, else 0. Bcd_Error holds until the next capture.
- Switches are sampled through their own 2-flop synchroniser. Capture uses the synchronised copy.
- Simultaneous events:
  - Start and Load pulses in the same cycle: Load wins, and Start_Pulse is suppressed for that press.
  - Sel is independent and may coincide with either.
- Reset (asynchronous, any time including mid-debounce):
  - Synchronisers, counters and stable levels go to 0.
  - Outputs reset: Start_Pulse=0, Load_Pulse=0, Target_Value=8'h00, Bcd_Error=0, Display_Sel=0.
  - A button held through reset release is accepted as a new press after the full debounce latency.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Press latency: raw level steady and first sampled at edge 1 → pulse high after edge DEBOUNCE_CYCLES+3, low after the following edge. Exactly 1 cycle wide.
- Target_Value and Bcd_Error update on the same edge that raises Load_Pulse, so the downstream timer sees the new value in the same cycle as the pulse.
- Display_Sel toggles on the edge that would raise the Sel pulse.
- Minimum re-press interval: a release must be stable DEBOUNCE_CYCLES cycles before a new press can be accepted.
- Switches must be stable for ≥3 cycles before Load_Pulse for a deterministic capture.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Reset then idle → all outputs 0, Target_Value=8'h00, for 20 cycles.
- Switches=8'h47, Btn_Load held 10 cycles → one Load_Pulse 7 cycles after the first sample; Target_Value=8'h47, Bcd_Error=0. No second pulse on release.
- Btn_Start glitches of 1, 2 and 3 cycles, then a held press → no pulse for any glitch; exactly one Start_Pulse for the held press.
- Switches=8'hA3, Load press → Target_Value=8'h93, Bcd_Error=1. Then Switches=8'h12 and Load → Target_Value=8'h12, Bcd_Error=0.
- Btn_Start and Btn_Load pressed on the same cycle → Load_Pulse only, Start_Pulse stays 0. Then 3 Sel presses → Display_Sel goes 1, 0, 1.
- Enable=0 during a Start press, Enable→1 while still held → no Start_Pulse. Separately, assert Reset mid-debounce of Load → Target_Value stays 8'h00, and the press is re-accepted 7 cycles after reset release.
